// File: rtl/mem_pkg.sv
// Shared types for the memory stage: access sizes, FSM states and the E->M bundle.
package mem_pkg;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10
  } memsize_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mstate_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic [1:0]  memsize;
    logic        memsigned;
    logic        arm;
    logic        memop;
  } em_t;

  // Size code 2'b11 behaves as a word, so it is misaligned exactly like MS_WORD.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MS_BYTE: return 1'b0;
      MS_HALF: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/flopenr.sv
// Resettable register with load enable; synchronous active-high reset.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_lane.sv
// Combinational byte-lane logic: store replication, lane strobes, load extract and extend.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata_o  = wd_i;
    be_o     = 4'b1111;
    rdext_o  = rdata_i;
    byte_sel = rdata_i[7:0];
    half_sel = rdata_i[15:0];
    case (size_i)
      MS_BYTE: begin
        case (a_i)
          2'd0:    byte_sel = rdata_i[7:0];
          2'd1:    byte_sel = rdata_i[15:8];
          2'd2:    byte_sel = rdata_i[23:16];
          default: byte_sel = rdata_i[31:24];
        endcase
        wdata_o = {4{wd_i[7:0]}};
        be_o    = 4'b0001 << a_i;
        rdext_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
      end
      MS_HALF: begin
        // a[0] is ignored: with the trap disabled a half access is forced to its aligned lane pair.
        half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wdata_o  = {2{wd_i[15:0]}};
        be_o     = a_i[1] ? 4'b1100 : 4'b0011;
        rdext_o  = {{16{sgn_i & half_sel[15]}}, half_sel};
      end
      default: begin
        wdata_o = wd_i;
        be_o    = 4'b1111;
        rdext_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/stage_m.sv
// Memory stage: E/M register plus req/ack data-memory FSM; MISALIGN_TRAP_EN enables the misalignment trap.
// Memory ops take ACCESS (>=1 cycle, until MemAck) then DONE; StallM holds F/D/E/M during ACCESS.
module stage_m
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [1:0]      MemSizeE,
  input  logic            MemSignedE,
  input  logic            armE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [1:0]      ResultSrcM,
  output logic            armM,
  output logic            RegWriteM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            MemReq,
  output logic            MemWe,
  output logic [XLEN-1:0] DataAdr,
  output logic [XLEN-1:0] MemWdata,
  output logic [3:0]      ByteEn,
  input  logic            MemAck,
  input  logic [XLEN-1:0] MemRdata,
  output logic            StallM,
  output logic            MisalignM
);

  em_t         em_d, em_q;
  mstate_t     state_q;
  logic        req_q, mis_q, mis_e;
  logic [31:0] rdata_q;
  logic [31:0] lane_wdata, lane_rdext;
  logic [3:0]  lane_be;

  assign em_d = '{
    alu:       ALUResultE,
    wd:        WriteDataE,
    rd:        RdE,
    pc4:       PCPlus4E,
    regwrite:  RegWriteE,
    memwrite:  MemWriteE,
    resultsrc: ResultSrcE,
    memsize:   MemSizeE,
    memsigned: MemSignedE,
    arm:       armE,
    memop:     MemWriteE | (ResultSrcE == RES_LOAD)
  };

  flopenr #(.WIDTH($bits(em_t))) u_em_reg (
    .clk (clk),
    .rst (rst),
    .en  (~StallM),
    .d   (em_d),
    .q   (em_q)
  );

`ifdef MISALIGN_TRAP_EN
  assign mis_e = em_d.memop & misaligned(MemSizeE, ALUResultE[1:0]);
`else
  assign mis_e = 1'b0;
`endif

  // The register captures E exactly when we are not in ACCESS, so the FSM decides on em_d then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      mis_q <= 1'b0;
      case (state_q)
        ACCESS: begin
          if (MemAck) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            rdata_q <= MemRdata;
          end
        end
        default: begin
          if (em_d.memop && mis_e) begin
            state_q <= DONE;
            mis_q   <= 1'b1;
          end else if (em_d.memop) begin
            state_q <= ACCESS;
            req_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  generate
    if (MAX_WAIT != 0) begin : g_ack_timeout
      logic [15:0] wait_q;
      always_ff @(posedge clk) begin
        if (rst || state_q != ACCESS) begin
          wait_q <= '0;
        end else if (!MemAck) begin
          assert (wait_q < 16'(MAX_WAIT));
          wait_q <= wait_q + 16'd1;
        end
      end
    end
  endgenerate

  mem_lane u_lane (
    .size_i  (em_q.memsize),
    .sgn_i   (em_q.memsigned),
    .a_i     (em_q.alu[1:0]),
    .wd_i    (em_q.wd),
    .rdata_i (rdata_q),
    .wdata_o (lane_wdata),
    .be_o    (lane_be),
    .rdext_o (lane_rdext)
  );

  assign ALUResultM = em_q.alu;
  assign RdM        = em_q.rd;
  assign PCPlus4M   = em_q.pc4;
  assign ResultSrcM = em_q.resultsrc;
  assign armM       = em_q.arm;
  assign StallM     = req_q;
  assign MemReq     = req_q;
  assign MisalignM  = mis_q;
  // Suppressing the write while stalled leaves one W bubble per wait cycle; the load writes in DONE only.
  assign RegWriteM  = em_q.regwrite & ~StallM & ~MisalignM;
  assign MemWe      = em_q.memwrite;
  assign DataAdr    = {em_q.alu[31:2], 2'b00};
  assign MemWdata   = lane_wdata;
  assign ByteEn     = em_q.memop ? lane_be : 4'b0000;
  assign ReadDataM  = lane_rdext;

endmodule

// File: tb/tb_stage_m.sv
// Randomized bench for stage_m: drives instructions like the hazard unit would and models a memory responder.
module tb_stage_m;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, MemSignedE, armE;
  logic [1:0]  ResultSrcE, MemSizeE;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM, DataAdr, MemWdata, MemRdata;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic        armM, RegWriteM, MemReq, MemWe, MemAck, StallM, MisalignM;
  logic [3:0]  ByteEn;

  int checks = 0;
  int errors = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  stage_m dut (
    .clk(clk), .rst(rst),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .armE(armE),
    .ALUResultM(ALUResultM), .RdM(RdM), .PCPlus4M(PCPlus4M), .ResultSrcM(ResultSrcM),
    .armM(armM), .RegWriteM(RegWriteM), .ReadDataM(ReadDataM),
    .MemReq(MemReq), .MemWe(MemWe), .DataAdr(DataAdr), .MemWdata(MemWdata),
    .ByteEn(ByteEn), .MemAck(MemAck), .MemRdata(MemRdata),
    .StallM(StallM), .MisalignM(MisalignM)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
    int off;
    if (sz == 2'd0)      begin off = int'(a % 4); return 4'(1 << off); end
    else if (sz == 2'd1) begin off = int'(a % 4) / 2 * 2; return 4'(3 << off); end
    else                 return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0)      return (wd % 256) * 32'h0101_0101;
    else if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
    else                 return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sgn, input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (d >> (8 * int'(a % 4))) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (int'(a % 4) / 2))) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic bit exp_mis(input logic [31:0] a, input logic [1:0] sz);
    if (!TRAP)           return 1'b0;
    else if (sz == 2'd0) return 1'b0;
    else if (sz == 2'd1) return (a % 2) != 0;
    else                 return (a % 4) != 0;
  endfunction

  task automatic drive_nop();
    ALUResultE = $urandom; WriteDataE = $urandom; PCPlus4E = $urandom; RdE = 5'($urandom);
    RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'b00; MemSizeE = 2'b00;
    MemSignedE = 1'b0; armE = 1'b0;
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store. Called just after a negedge while M is not stalled.
  task automatic run(input int kind, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic sgn, input logic [31:0] rdat, input int waits);
    logic        rw, arm, mis;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  rs;
    rw  = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
    rd  = 5'($urandom);
    pc  = $urandom;
    arm = 1'($urandom);
    rs  = (kind == 1) ? 2'b01 : ((kind == 0 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b00);
    mis = (kind != 0) && exp_mis(a, sz);
    ALUResultE = a; WriteDataE = wd; RdE = rd; PCPlus4E = pc; RegWriteE = rw;
    MemWriteE = (kind == 2); ResultSrcE = rs; MemSizeE = sz; MemSignedE = sgn; armE = arm;
    MemAck = 1'($urandom);
    MemRdata = $urandom;
    @(negedge clk);
    if (kind != 0 && !mis) begin
      for (int k = 0; k <= waits; k++) begin
        chk("acc_req", 32'(MemReq), 32'd1);
        chk("acc_stall", 32'(StallM), 32'd1);
        chk("acc_regwrite", 32'(RegWriteM), 32'd0);
        chk("acc_mis", 32'(MisalignM), 32'd0);
        chk("acc_we", 32'(MemWe), 32'(kind == 2));
        chk("acc_adr", DataAdr, a & 32'hFFFF_FFFC);
        chk("acc_be", 32'(ByteEn), 32'(exp_be(a, sz)));
        chk("acc_alu_hold", ALUResultM, a);
        if (kind == 2) chk("acc_wdata", MemWdata, exp_wdata(wd, sz));
        // Stalled E inputs are junk; the M register must hold.
        ALUResultE = $urandom; WriteDataE = $urandom; RegWriteE = 1'($urandom);
        MemWriteE = 1'($urandom); ResultSrcE = 2'($urandom); MemSizeE = 2'($urandom);
        MemAck   = (k == waits);
        MemRdata = (k == waits) ? rdat : $urandom;
        @(negedge clk);
      end
      MemAck = 1'b0;
    end
    chk("out_req", 32'(MemReq), 32'd0);
    chk("out_stall", 32'(StallM), 32'd0);
    chk("out_mis", 32'(MisalignM), 32'(mis));
    chk("out_regwrite", 32'(RegWriteM), 32'(rw && !mis));
    chk("out_alu", ALUResultM, a);
    chk("out_rd", 32'(RdM), 32'(rd));
    chk("out_pc4", PCPlus4M, pc);
    chk("out_rsrc", 32'(ResultSrcM), 32'(rs));
    chk("out_arm", 32'(armM), 32'(arm));
    if (kind == 1 && !mis) chk("out_rdata", ReadDataM, exp_load(a, sz, sgn, rdat));
  endtask

  initial begin
    rst = 1'b1;
    MemAck = 1'b0;
    MemRdata = '0;
    drive_nop();
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(MemReq), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regwrite", 32'(RegWriteM), 32'd0);
    chk("rst_mis", 32'(MisalignM), 32'd0);
    chk("rst_alu", ALUResultM, 32'd0);
    chk("rst_adr", DataAdr, 32'd0);
    chk("rst_be", 32'(ByteEn), 32'd0);
    chk("rst_wdata", MemWdata, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_we", 32'(MemWe), 32'd0);
    rst = 1'b0;

    // Directed cases
    run(2, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 0);
    run(1, 32'h0000_0103, 32'h0, 2'b00, 1'b1, 32'h80FF_FF00, 3);
    run(1, 32'h0000_0102, 32'h0, 2'b01, 1'b0, 32'h8001_0000, 1);
    run(2, 32'h0000_0101, 32'h0000_00AB, 2'b00, 1'b0, 32'h0, 2);
    run(1, 32'h0000_0200, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 0);
    run(1, 32'h0000_0204, 32'h0, 2'b10, 1'b0, 32'h9ABC_DEF0, 1);
    run(0, 32'h0000_0042, 32'h0, 2'b00, 1'b0, 32'h0, 0);
    run(1, 32'h0000_0102, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 0);
    run(1, 32'h0000_0301, 32'h0, 2'b01, 1'b1, 32'h00FF_80FF, 1);

    // Reset in the middle of ACCESS, then an ack arriving too late
    drive_nop();
    ALUResultE = 32'h0000_0400; ResultSrcE = 2'b01; RegWriteE = 1'b1; MemSizeE = 2'b10;
    MemAck = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(MemReq), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstacc_req", 32'(MemReq), 32'd0);
    chk("rstacc_stall", 32'(StallM), 32'd0);
    chk("rstacc_regwrite", 32'(RegWriteM), 32'd0);
    rst = 1'b0;
    drive_nop();
    MemAck = 1'b1;
    MemRdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("late_req", 32'(MemReq), 32'd0);
    chk("late_regwrite", 32'(RegWriteM), 32'd0);
    chk("late_rdata", ReadDataM, 32'd0);
    MemAck = 1'b0;
    @(negedge clk);
    chk("late_req2", 32'(MemReq), 32'd0);

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      run($urandom_range(0, 2), $urandom, $urandom, 2'($urandom), 1'($urandom),
          $urandom, $urandom_range(0, 4));
    end

    drive_nop();
    MemAck = 1'b0;
    @(negedge clk);
    chk("end_req", 32'(MemReq), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
